// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p OBI instruction-side slice.
//   obi_instr_rsp_t : one queued instruction-fetch response (read data + error flag)
//   OBI_INSTR_RSP_W : packed width of obi_instr_rsp_t, used to size the response FIFO
package cv32e40p_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_instr_rsp_t;

  localparam int OBI_INSTR_RSP_W = 33;

endpackage

// File: rtl/cv32e40p_fifo.sv
// Small synchronous FIFO with optional fall-through.
//   clk, rst_n : clock, asynchronous active-low reset (clears occupancy only)
//   push_i     : write data_i this cycle
//   data_i     : write data
//   pop_i      : consume the head entry this cycle
//   data_o     : head entry (registered storage unless fall-through bypass is active)
//   full_o     : DEPTH entries stored
//   empty_o    : no entry available at data_o
// DEPTH must be a power of 2 so the pointers wrap naturally.
module cv32e40p_fifo #(
  parameter bit FALL_THROUGH = 1'b0,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W:0]       usage;
  logic                  bypass;
  logic                  do_write;
  logic                  do_read;

  // In fall-through mode an empty FIFO presents the incoming word directly;
  // if it is popped in the same cycle it never needs to be stored.
  assign bypass   = FALL_THROUGH && (usage == '0) && push_i;
  assign do_write = push_i && !(bypass && pop_i);
  assign do_read  = pop_i && (usage != '0);

  assign full_o  = (usage == DEPTH_C);
  assign empty_o = (usage == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_write, do_read})
        2'b10:   usage <= usage + (ADDR_W+1)'(1);
        2'b01:   usage <= usage - (ADDR_W+1)'(1);
        default: usage <= usage;
      endcase
    end
  end

  // Storage carries data only; occupancy above decides what is valid.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_obi_instr_responder.sv
// Read-only OBI responder for the instruction fetch port (memory-side end).
// Grants requests, reads an external synchronous single-port SRAM with 1-cycle
// read latency and returns responses strictly in grant order.
//   clk, rst_n     : clock, asynchronous active-low reset
//   obi_req_i      : address-phase request
//   obi_gnt_o      : grant (combinational)
//   obi_addr_i     : byte address, bits [1:0] ignored
//   obi_we_i       : write enable; writes are answered with err=1
//   obi_rvalid_o   : response valid
//   obi_rdata_o    : response data, 0 when obi_rvalid_o=0
//   obi_err_o      : response error, 0 when obi_rvalid_o=0
//   gnt_stall_i    : test hook, forces obi_gnt_o=0
//   rsp_stall_i    : test hook, holds back responses
//   mem_req_o      : SRAM read strobe
//   mem_addr_o     : SRAM word address
//   mem_rdata_i    : SRAM read data, valid the cycle after mem_req_o
module cv32e40p_obi_instr_responder
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MEM_SIZE = 4096,
  parameter int MEM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  input  logic              obi_we_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  input  logic              gnt_stall_i,
  input  logic              rsp_stall_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [31:0]      MEM_LIMIT = 32'(MEM_SIZE);

  // Anything outside the backing memory or any write is answered with an error
  // and never reaches the SRAM.
  function automatic logic classify_err(input logic we, input logic [31:0] addr);
    return we | (addr >= MEM_LIMIT);
  endfunction

  logic [CNT_W-1:0]           cnt;
  logic                       gnt;
  logic                       pop;
  logic                       req_err_p0;
  logic                       vld_p1;
  logic                       err_p1;
  logic                       fifo_full;
  logic                       fifo_empty;
  obi_instr_rsp_t             rsp_p1;
  logic [OBI_INSTR_RSP_W-1:0] head_raw;
  obi_instr_rsp_t             head_rsp;

  // ---- Stage p0: address phase (grant, classify, SRAM strobe) ----
  assign req_err_p0 = classify_err(obi_we_i, obi_addr_i);
  assign pop        = !fifo_empty && !rsp_stall_i;
  // A pop in this cycle frees a slot immediately, so a full counter does not
  // block a grant when a response is leaving at the same time.
  assign gnt        = obi_req_i && !gnt_stall_i && ((cnt < DEPTH_C) || pop);

  assign obi_gnt_o  = gnt;
  assign mem_req_o  = gnt && !req_err_p0;
  assign mem_addr_o = obi_addr_i[MEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt && !pop) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !gnt) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= gnt;
  end

  always_ff @(posedge clk) begin
    err_p1 <= req_err_p0;
  end

  // ---- Stage p1: SRAM data returns, response enters the FIFO ----
  always_comb begin
    rsp_p1.rdata = err_p1 ? 32'h0 : mem_rdata_i;
    rsp_p1.err   = err_p1;
  end

  cv32e40p_fifo #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (OBI_INSTR_RSP_W),
    .DEPTH        (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_p1),
    .data_i  (rsp_p1),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---- Stage p2: response phase from the FIFO head ----
  assign head_rsp     = obi_instr_rsp_t'(head_raw);
  assign obi_rvalid_o = pop;
  assign obi_rdata_o  = pop ? head_rsp.rdata : 32'h0;
  assign obi_err_o    = pop ? head_rsp.err : 1'b0;

  // The outstanding counter bounds pipe + FIFO occupancy, so these never fire.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(vld_p1 && fifo_full && !pop));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule
